// File: rtl/dds_seq.sv
// DDS tone-table loader: soft-resets the DDS, writes theta/delta/ampl per tone, then starts it.
// Define DDS_SEQ_SAMPLE_TIMER_EN to build the internal sample-rate timer instead of using i_ext_tick.
module dds_seq #(
  parameter int SIG_WIDTH = 16,
  parameter int THETAS    = 0,
  parameter int DELTAS    = 1,
  parameter int AMPLS     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_cmd_load,
  input  logic                 i_cmd_stop,
  input  logic [31:0]          i_lngth,
  input  logic [31:0]          i_clk_div,
  input  logic                 i_ext_tick,
  input  logic                 i_tone_valid,
  output logic                 o_tone_ready,
  input  logic [SIG_WIDTH-1:0] i_tone_theta,
  input  logic [SIG_WIDTH-1:0] i_tone_delta,
  input  logic [SIG_WIDTH-1:0] i_tone_ampl,
  output logic [31:0]          o_dds_addrs,
  output logic                 o_dds_write,
  output logic [31:0]          o_dds_thetas_reg,
  output logic [31:0]          o_dds_deltas_reg,
  output logic [31:0]          o_dds_ampls_reg,
  output logic [31:0]          o_dds_ctrl_reg,
  output logic [31:0]          o_dds_lngth_reg,
  output logic                 o_dds_sample_en,
  output logic                 o_busy,
  output logic                 o_running,
  output logic                 o_err
);

  typedef enum logic [2:0] {
    IDLE, CLR, WAIT, WR_T, WR_D, WR_A, RUN
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [31:0] cnt;
  logic [31:0] cnt_inc;
  logic        load_ok;
  logic        load_bad;
  logic        hs;

  function automatic logic len_ok(input logic [31:0] l);
    case (l)
      32'd1, 32'd8, 32'd16, 32'd32,
      32'd64, 32'd128, 32'd256, 32'd512:
        len_ok = 1'b1;
      default:
        len_ok = 1'b0;
    endcase
  endfunction

  assign cnt_inc = cnt + 32'd1;

  // Stop beats every other request, including a coincident load.
  always_comb begin
    nxt      = state;
    load_ok  = 1'b0;
    load_bad = 1'b0;
    hs       = 1'b0;
    if (i_cmd_stop) begin
      nxt = IDLE;
    end else begin
      unique case (state)
        IDLE, RUN: begin
          if (i_cmd_load) begin
            if (len_ok(i_lngth)) begin
              nxt     = CLR;
              load_ok = 1'b1;
            end else begin
              load_bad = 1'b1;
            end
          end
        end
        CLR:  nxt = WAIT;
        WAIT: begin
          if (i_tone_valid) begin
            nxt = WR_T;
            hs  = 1'b1;
          end
        end
        WR_T: nxt = WR_D;
        WR_D: nxt = WR_A;
        WR_A: begin
          if (cnt_inc == o_dds_lngth_reg)
            nxt = RUN;
          else
            nxt = WAIT;
        end
        default: nxt = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      o_tone_ready     <= 1'b0;
      o_dds_addrs      <= '0;
      o_dds_write      <= 1'b0;
      o_dds_thetas_reg <= '0;
      o_dds_deltas_reg <= '0;
      o_dds_ampls_reg  <= '0;
      o_dds_ctrl_reg   <= '0;
      o_dds_lngth_reg  <= '0;
      o_busy           <= 1'b0;
      o_running        <= 1'b0;
      o_err            <= 1'b0;
    end else begin
      state <= nxt;
      if (load_ok) begin
        o_dds_lngth_reg <= i_lngth;
        cnt             <= '0;
        o_err           <= 1'b0;
      end
      if (load_bad)
        o_err <= 1'b1;
      if (hs) begin
        o_dds_thetas_reg <= 32'(i_tone_theta);
        o_dds_deltas_reg <= 32'(i_tone_delta);
        o_dds_ampls_reg  <= 32'(i_tone_ampl);
      end
      if (state == WR_A)
        cnt <= cnt_inc;
      o_tone_ready <= (nxt == WAIT);
      o_running    <= (nxt == RUN);
      o_busy       <= (nxt != IDLE) && (nxt != RUN);
      o_dds_write  <= 1'b0;
      o_dds_addrs  <= '0;
      o_dds_ctrl_reg <= '0;
      unique case (nxt)
        CLR:  o_dds_ctrl_reg <= 32'd1;
        RUN:  o_dds_ctrl_reg <= 32'd2;
        WR_T: begin
          o_dds_write <= 1'b1;
          o_dds_addrs <= 32'(THETAS);
        end
        WR_D: begin
          o_dds_write <= 1'b1;
          o_dds_addrs <= 32'(DELTAS);
        end
        WR_A: begin
          o_dds_write <= 1'b1;
          o_dds_addrs <= 32'(AMPLS);
        end
        default: ;
      endcase
    end
  end

`ifdef DDS_SEQ_SAMPLE_TIMER_EN
  logic [31:0] tcnt;
  logic [31:0] tcnt_inc;
  logic [31:0] period;
  logic        sample_q;
  logic        unused_tick;

  assign unused_tick = i_ext_tick;
  assign period      = (i_clk_div == 32'd0) ? 32'd1 : i_clk_div;
  assign tcnt_inc    = tcnt + 32'd1;

  // tcnt holds cycles since RUN entry modulo the period.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt     <= '0;
      sample_q <= 1'b0;
    end else if (nxt == RUN && state != RUN) begin
      tcnt     <= '0;
      sample_q <= (i_clk_div == 32'd0);
    end else if (nxt == RUN) begin
      if (tcnt_inc >= period) begin
        tcnt     <= '0;
        sample_q <= 1'b1;
      end else begin
        tcnt     <= tcnt_inc;
        sample_q <= 1'b0;
      end
    end else begin
      tcnt     <= '0;
      sample_q <= 1'b0;
    end
  end

  assign o_dds_sample_en = sample_q;
`else
  logic unused_div;

  assign unused_div      = ^i_clk_div;
  assign o_dds_sample_en = i_ext_tick & o_running;
`endif

endmodule
